// File: rtl/sc_bus_pkg.sv
// Shared definitions for the sc data-memory bus: owner-state encoding,
// master indices and the default hold limit.
package sc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_state_e;

    localparam int unsigned M0 = 32'd0;
    localparam int unsigned M1 = 32'd1;

    localparam int unsigned DEFAULT_MAX_HOLD = 32'd8;

endpackage

// File: rtl/sc_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// master that was not served last.
module sc_rr_pick2
    import sc_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic [1:0] gnt
);

    // Onehot grant from the request pair and the last-served index
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (rr_last == M1[0]) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Arbitrates the single sc_datamem port between the CPU (M0) and the
// debug/loader master (M1): round-robin with burst lock and a bounded hold.
module sc_dmem_arbiter
    import sc_bus_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);

    own_state_e    state_r;
    logic          rr_last_r;
    logic [HW-1:0] hold_cnt_r;
    logic [1:0]    rd_pend_r;
    logic [AW-1:0] addr_hold_r;
    logic [DW-1:0] wdata_hold_r;

    logic [1:0]    req_s;
    logic [1:0]    rr_gnt_s;
    logic [1:0]    gnt_s;
    logic          hold_ok_s;
    logic          win_s;
    logic          win_lock_s;
    own_state_e    win_state_s;
    logic [AW-1:0] mux_addr_s;
    logic [DW-1:0] mux_wdata_s;
    logic          mux_we_s;

    assign req_s     = {m1_req, m0_req};
    assign hold_ok_s = (hold_cnt_r < MAX_HOLD_C);

    sc_rr_pick2 u_pick (
        .req     (req_s),
        .rr_last (rr_last_r),
        .gnt     (rr_gnt_s)
    );

    // Grant decision: owner keeps the port until its hold budget runs out while the other waits
    always_comb begin
        gnt_s = 2'b00;
        if (reset) begin
            gnt_s = 2'b00;
        end else begin
            case (state_r)
                IDLE: gnt_s = rr_gnt_s;
                OWN0: begin
                    if (m0_req && (hold_ok_s || !m1_req)) gnt_s = 2'b01;
                    else if (m1_req)                      gnt_s = 2'b10;
                    else                                  gnt_s = 2'b00;
                end
                OWN1: begin
                    if (m1_req && (hold_ok_s || !m0_req)) gnt_s = 2'b10;
                    else if (m0_req)                      gnt_s = 2'b01;
                    else                                  gnt_s = 2'b00;
                end
                default: gnt_s = rr_gnt_s;
            endcase
        end
    end

    assign win_s       = gnt_s[1];
    assign win_lock_s  = win_s ? m1_lock : m0_lock;
    assign win_state_s = win_s ? OWN1 : OWN0;

    // Memory-side mux; address and data park on the last beat when nobody is granted
    always_comb begin
        mux_addr_s  = addr_hold_r;
        mux_wdata_s = wdata_hold_r;
        mux_we_s    = 1'b0;
        if (gnt_s[1]) begin
            mux_addr_s  = m1_addr;
            mux_wdata_s = m1_wdata;
            mux_we_s    = m1_we;
        end else if (gnt_s[0]) begin
            mux_addr_s  = m0_addr;
            mux_wdata_s = m0_wdata;
            mux_we_s    = m0_we;
        end else begin
            mux_we_s    = 1'b0;
        end
    end

    // Owner FSM, hold counter, read-return tags and parked bus values
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            rr_last_r    <= 1'b1;
            hold_cnt_r   <= {HW{1'b0}};
            rd_pend_r    <= 2'b00;
            addr_hold_r  <= {AW{1'b0}};
            wdata_hold_r <= {DW{1'b0}};
        end else begin
            rd_pend_r <= {gnt_s[1] & ~m1_we, gnt_s[0] & ~m0_we};
            if (gnt_s != 2'b00) begin
                rr_last_r    <= win_s;
                addr_hold_r  <= mux_addr_s;
                wdata_hold_r <= mux_wdata_s;
                if (win_lock_s) begin
                    state_r <= win_state_s;
                    if (state_r == win_state_s) begin
                        hold_cnt_r <= hold_ok_s ? (hold_cnt_r + HW'(1)) : hold_cnt_r;
                    end else begin
                        hold_cnt_r <= HW'(1);
                    end
                end else begin
                    state_r    <= IDLE;
                    hold_cnt_r <= {HW{1'b0}};
                end
            end else begin
                state_r    <= state_r;
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end

    assign m0_gnt    = gnt_s[0];
    assign m1_gnt    = gnt_s[1];
    // A read tag still pending when reset hits is dropped, not delivered
    assign m0_rvalid = rd_pend_r[0] & ~reset;
    assign m1_rvalid = rd_pend_r[1] & ~reset;
    assign m0_rdata  = m0_rvalid ? mem_rdata : {DW{1'b0}};
    assign m1_rdata  = m1_rvalid ? mem_rdata : {DW{1'b0}};
    assign mem_addr  = reset ? {AW{1'b0}} : mux_addr_s;
    assign mem_wdata = reset ? {DW{1'b0}} : mux_wdata_s;
    assign mem_we    = mux_we_s;

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Directed bench for sc_dmem_arbiter with a one-cycle-latency memory model.
module tb_sc_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] mem_model [logic [31:0]];

    sc_dmem_arbiter #(.AW(32), .DW(32), .MAX_HOLD(8)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Memory stand-in: read-first, data returned one cycle after the address
    always @(posedge clock) begin
        if (reset) begin
            mem_model.delete();
            mem_rdata <= 32'd0;
        end else begin
            mem_rdata <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'd0;
            if (mem_we) mem_model[mem_addr] = mem_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n0, n1, beats, m0_cycle;
        logic m0_done;

        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 32'h4; m1_wdata = 32'h0;

        // 1: reset held with both requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
            check_eq("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
            check_eq("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
            check_eq("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
            check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clock);
        check_eq("post_rst_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        check_eq("post_rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        check_eq("post_rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        next_cycle();
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clock);
        check_eq("post_rst_rd_ret", {31'd0, m0_rvalid}, 32'd1);

        // 2: M0 writes then reads 0x10, M1 idle
        next_cycle();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hCAFE0010;
        @(negedge clock);
        check_eq("t2_wr_gnt", {31'd0, m0_gnt}, 32'd1);
        check_eq("t2_wr_we", {31'd0, mem_we}, 32'd1);
        next_cycle();
        m0_we = 1'b0;
        @(negedge clock);
        check_eq("t2_rd_gnt", {31'd0, m0_gnt}, 32'd1);
        check_eq("t2_rd_addr", mem_addr, 32'h10);
        check_eq("t2_rd_we", {31'd0, mem_we}, 32'd0);
        check_eq("t2_wr_no_rvalid", {31'd0, m0_rvalid}, 32'd0);
        next_cycle();
        m0_req = 1'b0;
        @(negedge clock);
        check_eq("t2_rvalid", {31'd0, m0_rvalid}, 32'd1);
        check_eq("t2_rdata", m0_rdata, 32'hCAFE0010);
        check_eq("t2_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);

        // 3: both request reads every cycle, no lock, starting from a fresh reset
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h24;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check_eq("t3_m0_gnt", {31'd0, m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("t3_m1_gnt", {31'd0, m1_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check_eq("t3_m0_rvalid", {31'd0, m0_rvalid}, (i > 0 && (i % 2 == 1)) ? 32'd1 : 32'd0);
            check_eq("t3_m1_rvalid", {31'd0, m1_rvalid}, (i > 0 && (i % 2 == 0)) ? 32'd1 : 32'd0);
            n0 += int'(m0_gnt);
            n1 += int'(m1_gnt);
            next_cycle();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check_eq("t3_m0_beats", n0, 32'd50);
        check_eq("t3_m1_beats", n1, 32'd50);

        // 4: M1 locked 20-beat write burst, M0 single write from burst beat 3
        beats = 0; m0_done = 1'b0; m0_cycle = -1;
        m0_we = 1'b1; m0_lock = 1'b0; m0_addr = 32'h3C; m0_wdata = 32'h0000003C;
        m1_we = 1'b1;
        for (int c = 0; c < 21; c++) begin
            m1_req   = (beats < 20);
            m1_lock  = (beats < 19);
            m1_addr  = 32'h100 + 32'(beats * 4);
            m1_wdata = 32'hB0000000 + 32'(beats);
            m0_req   = (c >= 2) && !m0_done;
            @(negedge clock);
            check_eq("t4_m0_gnt", {31'd0, m0_gnt}, (c == 8) ? 32'd1 : 32'd0);
            check_eq("t4_m1_gnt", {31'd0, m1_gnt}, (c != 8) ? 32'd1 : 32'd0);
            check_eq("t4_mem_we", {31'd0, mem_we}, 32'd1);
            if (m1_gnt) beats++;
            if (m0_gnt) begin
                m0_done  = 1'b1;
                m0_cycle = c;
            end
            next_cycle();
        end
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        check_eq("t4_m0_first_gnt_cycle", m0_cycle, 32'd8);
        check_eq("t4_m1_beats", beats, 32'd20);

        // 5: M0 locked but idle, M1 takes the port in the same cycle
        m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b1; m0_addr = 32'h08; m0_wdata = 32'hA5A50008;
        @(negedge clock);
        check_eq("t5_m0_lock_gnt", {31'd0, m0_gnt}, 32'd1);
        next_cycle();
        m0_req = 1'b0; m0_lock = 1'b0;
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b0; m1_addr = 32'h0C; m1_wdata = 32'h5A5A000C;
        @(negedge clock);
        check_eq("t5_m1_gnt", {31'd0, m1_gnt}, 32'd1);
        check_eq("t5_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        check_eq("t5_mem_addr", mem_addr, 32'h0C);
        check_eq("t5_mem_wdata", mem_wdata, 32'h5A5A000C);
        next_cycle();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h08;
        @(negedge clock);
        check_eq("t5_rd0_gnt", {31'd0, m0_gnt}, 32'd1);
        next_cycle();
        m0_addr = 32'h0C;
        @(negedge clock);
        check_eq("t5_rd1_gnt", {31'd0, m0_gnt}, 32'd1);
        check_eq("t5_rd0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        check_eq("t5_rd0_data", m0_rdata, 32'hA5A50008);
        next_cycle();
        m0_req = 1'b0;
        @(negedge clock);
        check_eq("t5_rd1_rvalid", {31'd0, m0_rvalid}, 32'd1);
        check_eq("t5_rd1_data", m0_rdata, 32'h5A5A000C);

        // 6: reset the cycle after a locked M0 read grant
        next_cycle();
        m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b1; m0_addr = 32'h08;
        @(negedge clock);
        check_eq("t6_rd_gnt", {31'd0, m0_gnt}, 32'd1);
        next_cycle();
        reset = 1'b1; m0_req = 1'b0; m0_lock = 1'b0;
        @(negedge clock);
        check_eq("t6_rvalid_in_rst", {31'd0, m0_rvalid}, 32'd0);
        check_eq("t6_rdata_in_rst", m0_rdata, 32'd0);
        next_cycle();
        reset = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0;
        @(negedge clock);
        check_eq("t6_rvalid_after", {31'd0, m0_rvalid}, 32'd0);
        check_eq("t6_state_idle", {30'd0, dut.state_r}, 32'd0);
        check_eq("t6_tie_m0", {31'd0, m0_gnt}, 32'd1);
        check_eq("t6_tie_m1", {31'd0, m1_gnt}, 32'd0);
        next_cycle();
        m0_req = 1'b0; m1_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
